// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction-fetch stage with a req/ack instruction-memory port,
// a drain state for abandoned requests and a one-entry buffer for responses arriving under StallD.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          r_state,      w_state_nxt;
  logic [XLEN-1:0] r_pcf,        w_pcf_nxt;
  logic [XLEN-1:0] r_drain_addr, w_drain_addr_nxt;
  logic [31:0]     r_hold_instr, w_hold_instr_nxt;
  logic [XLEN-1:0] r_hold_pc,    w_hold_pc_nxt;
  logic [31:0]     r_instr_d,    w_instr_d_nxt;
  logic [XLEN-1:0] r_pc_d,       w_pc_d_nxt;
  logic [XLEN-1:0] r_pc_plus4_d, w_pc_plus4_d_nxt;
  logic            r_valid_d,    w_valid_d_nxt;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_fire;
  logic [XLEN-1:0] w_pcf_plus4;
  logic [XLEN-1:0] w_hold_plus4;

  // Memory port decode; request is forced low while reset is asserted.
  assign imem_req  = ~rst & (r_state != S_HOLD);
  assign imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pcf;
  assign w_fire    = imem_req & imem_ack;

  // PCSrcE 2'b11 is reserved and behaves as sequential fetch.
  assign w_redirect   = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
  assign w_target     = (PCSrcE == 2'b10) ? (ALUResultE & ~XLEN'(1)) : PCTargetE;
  assign w_pcf_plus4  = r_pcf + XLEN'(4);
  assign w_hold_plus4 = r_hold_pc + XLEN'(4);

  assign InstrD   = r_instr_d;
  assign PCD      = r_pc_d;
  assign PCPlus4D = r_pc_plus4_d;
  assign ValidD   = r_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pcf        <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc    <= '0;
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pcf        <= w_pcf_nxt;
      r_drain_addr <= w_drain_addr_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_instr_d    <= w_instr_d_nxt;
      r_pc_d       <= w_pc_d_nxt;
      r_pc_plus4_d <= w_pc_plus4_d_nxt;
      r_valid_d    <= w_valid_d_nxt;
    end
  end

  // Next state, PC and IF/ID update; a bubble only touches InstrD/ValidD.
  always_comb begin
    w_state_nxt      = r_state;
    w_pcf_nxt        = r_pcf;
    w_drain_addr_nxt = r_drain_addr;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;
    w_instr_d_nxt    = r_instr_d;
    w_pc_d_nxt       = r_pc_d;
    w_pc_plus4_d_nxt = r_pc_plus4_d;
    w_valid_d_nxt    = r_valid_d;

    if (w_redirect) begin
      w_pcf_nxt     = w_target;
      w_instr_d_nxt = NOP_INSTR;
      w_valid_d_nxt = 1'b0;
      unique case (r_state)
        S_FETCH: begin
          if (!w_fire) begin
            w_drain_addr_nxt = r_pcf;
            w_state_nxt      = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_fire) begin
            w_state_nxt = S_FETCH;
          end
        end
        S_HOLD:  w_state_nxt = S_FETCH;
        default: w_state_nxt = S_FETCH;
      endcase
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_fire) begin
            w_pcf_nxt = w_pcf_plus4;
            if (FlushD) begin
              w_instr_d_nxt = NOP_INSTR;
              w_valid_d_nxt = 1'b0;
            end else if (StallD) begin
              w_hold_instr_nxt = imem_rdata;
              w_hold_pc_nxt    = r_pcf;
              w_state_nxt      = S_HOLD;
            end else begin
              w_instr_d_nxt    = imem_rdata;
              w_pc_d_nxt       = r_pcf;
              w_pc_plus4_d_nxt = w_pcf_plus4;
              w_valid_d_nxt    = 1'b1;
            end
          end else if (FlushD || !StallD) begin
            w_instr_d_nxt = NOP_INSTR;
            w_valid_d_nxt = 1'b0;
          end
        end
        S_DRAIN: begin
          if (FlushD || !StallD) begin
            w_instr_d_nxt = NOP_INSTR;
            w_valid_d_nxt = 1'b0;
          end
          if (w_fire) begin
            w_state_nxt = S_FETCH;
          end
        end
        S_HOLD: begin
          // The buffered response survives a flush; only a redirect discards it.
          if (FlushD) begin
            w_instr_d_nxt = NOP_INSTR;
            w_valid_d_nxt = 1'b0;
          end else if (!StallD) begin
            w_instr_d_nxt    = r_hold_instr;
            w_pc_d_nxt       = r_hold_pc;
            w_pc_plus4_d_nxt = w_hold_plus4;
            w_valid_d_nxt    = 1'b1;
            w_state_nxt      = S_FETCH;
          end
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed per-cycle vector table for fetch_stage plus hand-written
// sequences for async reset during a drain and PC wrap-around.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  src = 2'b00;
  logic [31:0] tgt = '0;
  logic [31:0] alu = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [31:0] iw(input logic [31:0] a);
    return 32'hC000_0000 | a;
  endfunction

  // Instruction memory contents: a fixed function of the address.
  assign imem_rdata = iw(imem_addr);

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrcE     (src),
    .PCTargetE  (tgt),
    .ALUResultE (alu),
    .StallD     (stall),
    .FlushD     (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (ack),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  typedef struct {
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] alu;
    logic        stall;
    logic        flush;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pcd;
    logic [31:0] e_p4;
    logic        e_valid;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [1:0] s, input logic [31:0] t, input logic [31:0] a,
                              input logic st, input logic fl, input logic ak,
                              input logic rq, input logic [31:0] ad, input logic [31:0] ins,
                              input logic [31:0] pc, input logic [31:0] p4, input logic vl);
    vec_t v;
    v.src = s; v.tgt = t; v.alu = a; v.stall = st; v.flush = fl; v.ack = ak;
    v.e_req = rq; v.e_addr = ad; v.e_instr = ins; v.e_pcd = pc; v.e_p4 = p4; v.e_valid = vl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic rq, input logic [31:0] ad,
                         input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] p4, input logic vl);
    chk({tag, "_req"},   32'(imem_req), 32'(rq));
    chk({tag, "_addr"},  imem_addr, ad);
    chk({tag, "_instr"}, InstrD, ins);
    chk({tag, "_pcd"},   PCD, pc);
    chk({tag, "_pcp4"},  PCPlus4D, p4);
    chk({tag, "_valid"}, 32'(ValidD), 32'(vl));
  endtask

  task automatic drive(input logic [1:0] s, input logic [31:0] t, input logic [31:0] a,
                       input logic st, input logic fl, input logic ak);
    src = s; tgt = t; alu = a; stall = st; flush = fl; ack = ak;
  endtask

  initial begin
    // Zero-wait stream, stall into HOLD, latency-3 fetches, redirects, flushes, reserved PCSrcE.
    vecs[0]  = mk(2'd0, 0, 0, 0, 0, 1,  1, 32'h000, NOP,          32'h000, 32'h000, 0);
    vecs[1]  = mk(2'd0, 0, 0, 0, 0, 1,  1, 32'h004, iw(32'h000),  32'h000, 32'h004, 1);
    vecs[2]  = mk(2'd0, 0, 0, 0, 0, 1,  1, 32'h008, iw(32'h004),  32'h004, 32'h008, 1);
    vecs[3]  = mk(2'd0, 0, 0, 0, 0, 1,  1, 32'h00C, iw(32'h008),  32'h008, 32'h00C, 1);
    vecs[4]  = mk(2'd0, 0, 0, 1, 0, 1,  1, 32'h010, iw(32'h00C),  32'h00C, 32'h010, 1);
    vecs[5]  = mk(2'd0, 0, 0, 1, 0, 0,  0, 32'h014, iw(32'h00C),  32'h00C, 32'h010, 1);
    vecs[6]  = mk(2'd0, 0, 0, 1, 0, 0,  0, 32'h014, iw(32'h00C),  32'h00C, 32'h010, 1);
    vecs[7]  = mk(2'd0, 0, 0, 0, 0, 0,  0, 32'h014, iw(32'h00C),  32'h00C, 32'h010, 1);
    vecs[8]  = mk(2'd0, 0, 0, 0, 0, 1,  1, 32'h014, iw(32'h010),  32'h010, 32'h014, 1);
    vecs[9]  = mk(2'd0, 0, 0, 0, 0, 0,  1, 32'h018, iw(32'h014),  32'h014, 32'h018, 1);
    vecs[10] = mk(2'd0, 0, 0, 0, 0, 0,  1, 32'h018, NOP,          32'h014, 32'h018, 0);
    vecs[11] = mk(2'd0, 0, 0, 0, 0, 1,  1, 32'h018, NOP,          32'h014, 32'h018, 0);
    vecs[12] = mk(2'd0, 0, 0, 0, 0, 0,  1, 32'h01C, iw(32'h018),  32'h018, 32'h01C, 1);
    vecs[13] = mk(2'd0, 0, 0, 0, 0, 0,  1, 32'h01C, NOP,          32'h018, 32'h01C, 0);
    vecs[14] = mk(2'd0, 0, 0, 0, 0, 1,  1, 32'h01C, NOP,          32'h018, 32'h01C, 0);
    vecs[15] = mk(2'd1, 32'h100, 0, 0, 0, 0,  1, 32'h020, iw(32'h01C), 32'h01C, 32'h020, 1);
    vecs[16] = mk(2'd0, 0, 0, 0, 0, 0,  1, 32'h020, NOP,          32'h01C, 32'h020, 0);
    vecs[17] = mk(2'd0, 0, 0, 0, 0, 1,  1, 32'h020, NOP,          32'h01C, 32'h020, 0);
    vecs[18] = mk(2'd0, 0, 0, 0, 0, 0,  1, 32'h100, NOP,          32'h01C, 32'h020, 0);
    vecs[19] = mk(2'd0, 0, 0, 0, 0, 0,  1, 32'h100, NOP,          32'h01C, 32'h020, 0);
    vecs[20] = mk(2'd0, 0, 0, 0, 0, 1,  1, 32'h100, NOP,          32'h01C, 32'h020, 0);
    vecs[21] = mk(2'd2, 0, 32'h203, 0, 0, 1,  1, 32'h104, iw(32'h100), 32'h100, 32'h104, 1);
    vecs[22] = mk(2'd0, 0, 0, 0, 0, 1,  1, 32'h202, NOP,          32'h100, 32'h104, 0);
    vecs[23] = mk(2'd0, 0, 0, 0, 1, 1,  1, 32'h206, iw(32'h202),  32'h202, 32'h206, 1);
    vecs[24] = mk(2'd0, 0, 0, 1, 1, 1,  1, 32'h20A, NOP,          32'h202, 32'h206, 0);
    vecs[25] = mk(2'd0, 0, 0, 1, 0, 0,  1, 32'h20E, NOP,          32'h202, 32'h206, 0);
    vecs[26] = mk(2'd3, 32'h400, 0, 0, 0, 0,  1, 32'h20E, NOP,    32'h202, 32'h206, 0);
    vecs[27] = mk(2'd0, 0, 0, 0, 0, 1,  1, 32'h20E, NOP,          32'h202, 32'h206, 0);
    vecs[28] = mk(2'd0, 0, 0, 0, 0, 0,  1, 32'h212, iw(32'h20E),  32'h20E, 32'h212, 1);
    vecs[29] = mk(2'd3, 32'h400, 0, 0, 0, 1,  1, 32'h212, NOP,    32'h20E, 32'h212, 0);
    vecs[30] = mk(2'd0, 0, 0, 1, 0, 1,  1, 32'h216, iw(32'h212),  32'h212, 32'h216, 1);
    vecs[31] = mk(2'd1, 32'h300, 0, 1, 0, 0,  0, 32'h21A, iw(32'h212), 32'h212, 32'h216, 1);
    vecs[32] = mk(2'd0, 0, 0, 0, 0, 1,  1, 32'h300, NOP,          32'h212, 32'h216, 0);
    vecs[33] = mk(2'd0, 0, 0, 0, 0, 0,  1, 32'h304, iw(32'h300),  32'h300, 32'h304, 1);

    @(negedge clk);
    chk_all("reset", 1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].src, vecs[i].tgt, vecs[i].alu, vecs[i].stall, vecs[i].flush, vecs[i].ack);
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_instr,
              vecs[i].e_pcd, vecs[i].e_p4, vecs[i].e_valid);
      @(posedge clk); #1;
    end

    // Redirect with request for 0x304 outstanding, then async reset while draining.
    drive(2'd1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain_enter_addr", imem_addr, 32'h304);
    @(posedge clk); #1;
    drive(2'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("drain_hold", 1'b1, 32'h304, NOP, 32'h300, 32'h304, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, NOP, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Redirect to the top of the address space and fetch across the wrap.
    drive(2'd1, 32'hFFFF_FFFC, 0, 0, 0, 1);
    @(negedge clk);
    chk_all("post_rst", 1'b1, 32'h0, NOP, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(2'd0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    drive(2'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("wrap", 1'b1, 32'h0, iw(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
